// File: rtl/seq_detect_prog.sv
// Runtime-programmable serial bit-pattern detector with selectable overlap,
// input-valid qualifier, registered match pulse and saturating match counter.
module seq_detect_prog #(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned LEN_W   = 4,
  parameter int unsigned CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic               in_bit,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               clr_count,
  output logic               match,
  output logic [CNT_W-1:0]   match_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [MAX_LEN-1:0] pattern;
  logic [LEN_W-1:0]   len;
  logic               overlap;
  logic [MAX_LEN-2:0] history;
  logic [LEN_W-1:0]   fill;

  logic [MAX_LEN-1:0] window_c;
  logic [MAX_LEN-1:0] mask_c;
  logic [MAX_LEN:0]   span_c;
  logic [LEN_W:0]     fill_inc_c;
  logic [LEN_W-1:0]   fill_next_c;
  logic [LEN_W-1:0]   len_load_c;
  logic               accept_c;
  logic               hit_c;

  // Compare the newest len bits (history plus the incoming bit) against the pattern.
  always_comb begin
    window_c   = {history, in_bit};
    span_c     = (MAX_LEN+1)'(1) << len;
    mask_c     = MAX_LEN'(span_c - (MAX_LEN+1)'(1));
    fill_inc_c = (LEN_W+1)'(fill) + (LEN_W+1)'(1);
    accept_c   = in_valid && !cfg_we;
    hit_c      = accept_c
                 && (len >= LEN_W'(2))
                 && (fill_inc_c >= (LEN_W+1)'(len))
                 && (((window_c ^ pattern) & mask_c) == '0);
    fill_next_c = (fill_inc_c > (LEN_W+1)'(len)) ? len : fill_inc_c[LEN_W-1:0];
    if (hit_c && !overlap) begin
      fill_next_c = '0;
    end
    len_load_c = (32'(cfg_len) > MAX_LEN) ? LEN_W'(MAX_LEN) : cfg_len;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pattern     <= MAX_LEN'(4'b1010);
      len         <= LEN_W'(4);
      overlap     <= 1'b1;
      history     <= '0;
      fill        <= '0;
      match       <= 1'b0;
      match_count <= '0;
    end else begin
      match <= hit_c;
      if (cfg_we) begin
        pattern <= cfg_pattern;
        len     <= len_load_c;
        overlap <= cfg_overlap;
        history <= '0;
        fill    <= '0;
      end else if (in_valid) begin
        history <= window_c[MAX_LEN-2:0];
        fill    <= fill_next_c;
      end
      // A clear coinciding with a match keeps that match as the first count.
      if (hit_c) begin
        if (clr_count) begin
          match_count <= CNT_W'(1);
        end else if (match_count != CNT_MAX) begin
          match_count <= match_count + CNT_W'(1);
        end
      end else if (clr_count) begin
        match_count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_seq_detect_prog.sv
// Directed self-checking bench for seq_detect_prog.
module tb_seq_detect_prog;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_bit;
  logic       cfg_we;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       cfg_overlap;
  logic       clr_count;
  logic       match;
  logic [7:0] match_count;

  int n_vec = 0;
  int n_err = 0;

  seq_detect_prog #(.MAX_LEN(8), .LEN_W(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit),
    .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .clr_count(clr_count),
    .match(match), .match_count(match_count)
  );

  always #5 clk = ~clk;

  // One clock: drive on the falling edge, return 1ns after the rising edge.
  task automatic cyc(input logic v, input logic b, input logic we, input logic clr);
    @(negedge clk);
    in_valid = v; in_bit = b; cfg_we = we; clr_count = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] pat, input logic [3:0] l, input logic ov);
    cfg_pattern = pat; cfg_len = l; cfg_overlap = ov;
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if (match !== 1'b0 || match_count !== 8'd0) begin
      n_err++;
      $display("FAIL reset: match=%b count=%0d, want 0/0", match, match_count);
    end
    reset = 1'b0;
  endtask

  task automatic test_defaults_overlap;
    logic [6:0] s = 7'b1010101;
    logic [6:0] e = 7'b0001010;
    for (int i = 6; i >= 0; i--) begin
      cyc(1'b1, s[i], 1'b0, 1'b0);
      n_vec++;
      if (match !== e[i]) begin
        n_err++;
        $display("FAIL t1_bit%0d: match=%b want %b", 7 - i, match, e[i]);
      end
    end
    n_vec++;
    if (match_count !== 8'd2) begin
      n_err++;
      $display("FAIL t1_count: got %0d want 2", match_count);
    end
  endtask

  task automatic test_non_overlap;
    logic [6:0] s = 7'b1010101;
    logic [6:0] e = 7'b0001000;
    load(8'b0000_1010, 4'd4, 1'b0);
    n_vec++;
    if (match_count !== 8'd0) begin
      n_err++;
      $display("FAIL t2_clr: count=%0d want 0", match_count);
    end
    for (int i = 6; i >= 0; i--) begin
      cyc(1'b1, s[i], 1'b0, 1'b0);
      n_vec++;
      if (match !== e[i]) begin
        n_err++;
        $display("FAIL t2_bit%0d: match=%b want %b", 7 - i, match, e[i]);
      end
    end
    n_vec++;
    if (match_count !== 8'd1) begin
      n_err++;
      $display("FAIL t2_count: got %0d want 1", match_count);
    end
  endtask

  task automatic test_len3_dont_care;
    logic [4:0] e = 5'b00111;
    // Bits above len are set on purpose; they must be ignored.
    load(8'b1010_0111, 4'd3, 1'b1);
    for (int i = 4; i >= 0; i--) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      n_vec++;
      if (match !== e[i]) begin
        n_err++;
        $display("FAIL t3_bit%0d: match=%b want %b", 5 - i, match, e[i]);
      end
    end
    n_vec++;
    if (match_count !== 8'd3) begin
      n_err++;
      $display("FAIL t3_count: got %0d want 3", match_count);
    end
  endtask

  task automatic test_gaps;
    logic [6:0] s = 7'b1010101;
    logic [6:0] e = 7'b0001010;
    load(8'b0000_1010, 4'd4, 1'b1);
    for (int i = 6; i >= 0; i--) begin
      cyc(1'b1, s[i], 1'b0, 1'b0);
      n_vec++;
      if (match !== e[i]) begin
        n_err++;
        $display("FAIL t4_bit%0d: match=%b want %b", 7 - i, match, e[i]);
      end
      for (int g = 0; g < 3; g++) begin
        cyc(1'b0, ~s[i], 1'b0, 1'b0);
        n_vec++;
        if (match !== 1'b0) begin
          n_err++;
          $display("FAIL t4_gap%0d_%0d: match=%b want 0", 7 - i, g, match);
        end
      end
    end
    n_vec++;
    if (match_count !== 8'd2) begin
      n_err++;
      $display("FAIL t4_count: got %0d want 2", match_count);
    end
  endtask

  task automatic test_reset_mid_and_len;
    logic [7:0] p = 8'b1011_0011;
    test_reset();
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    // Reset on the edge that would complete 1010: the match is dropped.
    reset = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    n_vec++;
    if (match !== 1'b0 || match_count !== 8'd0) begin
      n_err++;
      $display("FAIL t5_rst_pending: match=%b count=%0d want 0/0", match, match_count);
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if (match !== 1'b0 || match_count !== 8'd0) begin
      n_err++;
      $display("FAIL t5_after_rst: match=%b count=%0d want 0/0", match, match_count);
    end
    // len=1 disables detection.
    load(8'b0000_0001, 4'd1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      n_vec++;
      if (match !== 1'b0) begin
        n_err++;
        $display("FAIL t5_len1_%0d: match=%b want 0", i, match);
      end
    end
    // len=15 is clamped to 8: only the eighth bit completes the pattern.
    load(p, 4'd15, 1'b1);
    for (int i = 7; i >= 0; i--) begin
      cyc(1'b1, p[i], 1'b0, 1'b0);
      n_vec++;
      if (match !== (i == 0)) begin
        n_err++;
        $display("FAIL t5_len15_bit%0d: match=%b want %b", 8 - i, match, i == 0);
      end
    end
    n_vec++;
    if (match_count !== 8'd1) begin
      n_err++;
      $display("FAIL t5_len15_count: got %0d want 1", match_count);
    end
  endtask

  task automatic test_back_to_back;
    load(8'b0000_0011, 4'd2, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 330; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
    end
    n_vec++;
    if (match !== 1'b1 || match_count !== 8'd255) begin
      n_err++;
      $display("FAIL t6_saturate: match=%b count=%0d want 1/255", match, match_count);
    end
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    n_vec++;
    if (match !== 1'b1 || match_count !== 8'd1) begin
      n_err++;
      $display("FAIL t6_clr_on_match: match=%b count=%0d want 1/1", match, match_count);
    end
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    n_vec++;
    if (match !== 1'b0 || match_count !== 8'd0) begin
      n_err++;
      $display("FAIL t6_clr_alone: match=%b count=%0d want 0/0", match, match_count);
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_bit = 1'b0; cfg_we = 1'b0;
    cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0; clr_count = 1'b0;
    test_reset();
    test_defaults_overlap();
    test_non_overlap();
    test_len3_dont_care();
    test_gaps();
    test_reset_mid_and_len();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
